// File: rtl/test_status_pkg.sv
// Shared types and constants for the memory-mapped test-status responder.
package test_status_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0] PASS_WORD = 32'd1;
  localparam logic [15:0] CKPT_MAX  = 16'hFFFF;

endpackage

// File: rtl/test_status_mmio_if.sv
// Core data-memory bus as seen by the status responder.
interface test_status_mmio_if #(
  parameter int WIDTH = 32
);

  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/test_status_mmio_watchdog_counter.sv
// Enabled cycle counter that flags, and parks at, LIMIT-1.
module watchdog_counter #(
  parameter int CNT_W = 32,
  parameter int LIMIT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  assign expired = (count == CNT_W'(LIMIT - 1));

  // Count enabled cycles; hold once the limit value is reached so it stays readable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/test_status_mmio.sv
// Test-status responder: decodes firmware stores to one word address into
// sticky finish/error flags, a fail code and a checkpoint count, with a
// watchdog that ends the test if firmware stops making progress.
module test_status_mmio
  import test_status_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] STATUS_ADDR    = WIDTH'(32'h0000_1000),
  parameter int               TIMEOUT_CYCLES = 100000,
  parameter int               CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  test_status_mmio_if.slave   bus,
  output logic                finish,
  output logic                error,
  output logic [WIDTH-2:0]    fail_code,
  output logic [15:0]         checkpoints,
  output logic [CNT_W-1:0]    cycle_count
);

  state_t state;
  state_t state_next;
  logic   hit;
  logic   is_pass;
  logic   is_fail;
  logic   is_ckpt;
  logic   expired;
  logic   fail_load;
  logic   ckpt_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CKPT_MAX) ? v : v + 16'd1;
  endfunction

  // Word decode: the full address must match, so byte offsets never hit.
  assign hit     = bus.mem_we && (bus.mem_addr == STATUS_ADDR);
  assign is_pass = hit && (bus.mem_wdata == WIDTH'(PASS_WORD));
  assign is_fail = hit && bus.mem_wdata[0] && !is_pass;
  assign is_ckpt = hit && !bus.mem_wdata[0];

  watchdog_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state == RUN),
    .count   (cycle_count),
    .expired (expired)
  );

  // Next-state decode; terminal stores beat the watchdog, checkpoints do not.
  always_comb begin
    state_next = state;
    fail_load  = 1'b0;
    ckpt_inc   = 1'b0;
    if (state == RUN) begin
      if (is_pass) begin
        state_next = PASS;
      end else if (is_fail) begin
        state_next = FAIL;
        fail_load  = 1'b1;
      end else begin
        ckpt_inc = is_ckpt;
        if (expired) begin
          state_next = TIMEOUT;
        end
      end
    end
  end

  // State register with flags registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      finish <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      finish <= (state_next != RUN);
      error  <= (state_next == FAIL) || (state_next == TIMEOUT);
    end
  end

  // Fail code and checkpoint count, updated only by decoded RUN-state stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fail_code   <= '0;
      checkpoints <= '0;
    end else begin
      if (fail_load) begin
        fail_code <= bus.mem_wdata[WIDTH-1:1];
      end
      if (ckpt_inc) begin
        checkpoints <= sat_inc(checkpoints);
      end
    end
  end

  // Side-effect-free status read, independent of the store strobe.
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_addr == STATUS_ADDR) begin
      bus.mem_rdata = WIDTH'({checkpoints, 12'b0, state, error, finish});
    end
  end

endmodule

// File: tb/tb_test_status_mmio.sv
// Scoreboard bench for test_status_mmio with a short watchdog.
module tb_test_status_mmio;

  localparam int          WIDTH = 32;
  localparam int          CNT_W = 32;
  localparam int          TO    = 50;
  localparam logic [31:0] SA    = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              finish;
  logic              error;
  logic [WIDTH-2:0]  fail_code;
  logic [15:0]       checkpoints;
  logic [CNT_W-1:0]  cycle_count;

  always #5 clk = ~clk;

  test_status_mmio_if #(.WIDTH(WIDTH)) bus ();

  test_status_mmio #(
    .WIDTH          (WIDTH),
    .STATUS_ADDR    (SA),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .finish      (finish),
    .error       (error),
    .fail_code   (fail_code),
    .checkpoints (checkpoints),
    .cycle_count (cycle_count)
  );

  typedef struct packed {
    logic        fin;
    logic        err;
    logic [30:0] fc;
    logic [15:0] ck;
    logic [31:0] cc;
    logic [31:0] rd;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the responder, advanced once per driven cycle.
  logic [1:0]  m_st;
  logic        m_fin;
  logic        m_err;
  logic [30:0] m_fc;
  logic [15:0] m_ck;
  logic [31:0] m_cc;

  function automatic obs_t observe();
    obs_t o;
    o.fin = finish;
    o.err = error;
    o.fc  = fail_code;
    o.ck  = checkpoints;
    o.cc  = cycle_count;
    o.rd  = bus.mem_rdata;
    return o;
  endfunction

  // Drive one cycle, push the expected post-edge view, then step past the edge.
  task automatic cycle(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
    obs_t e;
    logic hit;
    rst           = r;
    bus.mem_we    = we;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    hit = we && (a == SA);
    if (!r) begin
      m_st = 2'd0; m_fc = '0; m_ck = '0; m_cc = '0;
    end else if (m_st == 2'd0) begin
      if (hit && d == 32'd1) begin
        m_st = 2'd1;
      end else if (hit && d[0]) begin
        m_st = 2'd2;
        m_fc = d[31:1];
      end else begin
        if (hit && m_ck != 16'hFFFF) m_ck = m_ck + 16'd1;
        if (m_cc == 32'(TO - 1)) m_st = 2'd3;
      end
      if (m_cc != 32'(TO - 1)) m_cc = m_cc + 32'd1;
    end
    m_fin = (m_st != 2'd0);
    m_err = (m_st == 2'd2) || (m_st == 2'd3);
    e.fin = m_fin;
    e.err = m_err;
    e.fc  = m_fc;
    e.ck  = m_ck;
    e.cc  = m_cc;
    e.rd  = (a == SA) ? {m_ck, 12'h000, m_st, m_err, m_fin} : 32'h0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, SA, 32'h0);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset[%0d]: got %h want %h", i, o, e); end
    end
    checks++;
    if ({finish, error, checkpoints, cycle_count, bus.mem_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_zero: fin=%b err=%b ck=%h cc=%0d rd=%h want all 0", finish, error, checkpoints, cycle_count, bus.mem_rdata);
    end
  endtask

  task automatic test_checkpoints();
    obs_t e, o;
    logic [31:0] data [7] = '{32'h2, 32'h2, 32'h2, 32'h1, 32'h7, 32'h2, 32'h0};
    cycle(1'b0, 1'b0, SA, 32'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, SA, data[i]);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL ckpt[%0d]: got %h want %h", i, o, e); end
      if (i == 3) begin
        checks++;
        if (checkpoints !== 16'd3 || finish !== 1'b1 || error !== 1'b0) begin
          errors++;
          $display("FAIL pass_flags: ck=%0d fin=%b err=%b want 3 1 0", checkpoints, finish, error);
        end
      end
    end
  endtask

  task automatic test_fail();
    obs_t e, o;
    cycle(1'b0, 1'b0, SA, 32'h0);
    void'(exp_q.pop_front());
    cycle(1'b1, 1'b1, SA, 32'h0000_0015);
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL fail_store: got %h want %h", o, e); end
    checks++;
    if (bus.mem_rdata !== 32'h0000_000B || fail_code !== 31'hA || finish !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL fail_view: rd=%h fc=%h fin=%b err=%b want 0000000b a 1 1", bus.mem_rdata, fail_code, finish, error);
    end
  endtask

  // Run with no stores, optionally placing one store on the last watchdog cycle.
  task automatic test_timeout(input logic late_we, input logic [31:0] late_data, input logic [1:0] want_st);
    obs_t e, o;
    cycle(1'b0, 1'b0, SA, 32'h0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= TO + 4; i++) begin
      cycle(1'b1, (i == TO) ? late_we : 1'b0, SA, late_data);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout[%0d]: got %h want %h", i, o, e); end
      if (i == TO - 1 || i == TO + 3) begin
        checks++;
        if (finish !== (i >= TO) || cycle_count !== 32'(i >= TO ? TO - 1 : i)) begin
          errors++;
          $display("FAIL timeout_edge[%0d]: fin=%b cc=%0d", i, finish, cycle_count);
        end
      end
    end
    checks++;
    if (bus.mem_rdata[3:2] !== want_st) begin
      errors++;
      $display("FAIL timeout_state: got %0d want %0d", bus.mem_rdata[3:2], want_st);
    end
  endtask

  task automatic test_decode();
    obs_t e, o;
    logic [31:0] addr [4] = '{SA + 32'd1, SA + 32'd4, SA + 32'd8, SA};
    logic        we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    cycle(1'b0, 1'b0, SA, 32'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, we[i], addr[i], 32'h1);
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin errors++; $display("FAIL decode[%0d]: got %h want %h", i, o, e); end
      if (i == 2) begin
        checks++;
        if (bus.mem_rdata !== 32'h0 || finish !== 1'b0) begin
          errors++;
          $display("FAIL decode_miss: rd=%h fin=%b want 0 0", bus.mem_rdata, finish);
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    obs_t e, o;
    cycle(1'b0, 1'b0, SA, 32'h0);
    void'(exp_q.pop_front());
    cycle(1'b1, 1'b1, SA, 32'h0000_0015);
    void'(exp_q.pop_front());
    cycle(1'b0, 1'b1, SA, 32'h1);
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL midop_reset: got %h want %h", o, e); end
    checks++;
    if ({finish, error, fail_code, checkpoints, cycle_count, bus.mem_rdata} !== '0) begin
      errors++;
      $display("FAIL midop_zero: fin=%b err=%b fc=%h rd=%h want all 0", finish, error, fail_code, bus.mem_rdata);
    end
    cycle(1'b1, 1'b0, SA, 32'h0);
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin errors++; $display("FAIL midop_after: got %h want %h", o, e); end
  endtask

  initial begin
    rst           = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    test_reset();
    test_checkpoints();
    test_fail();
    test_timeout(1'b0, 32'h0, 2'd3);
    test_timeout(1'b1, 32'h1, 2'd1);
    test_timeout(1'b1, 32'h2, 2'd3);
    test_decode();
    test_midop_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
